vram_rd_bridge: RTL and testbench



---
 rtl/chr_gen_pkg.sv | 20 ++
 rtl/chr_gen_tmo_ctr.sv | 31 +++
 rtl/vram_rd_bridge.sv | 145 ++++++++++++++
 tb/tb_vram_rd_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chr_gen_pkg.sv
// Shared CHR_GEN definitions: VRAM geometry, the readback FSM encoding and counter sizing.
package chr_gen_pkg;

   localparam int C_VRAM_AW = 10;
   localparam int C_VRAM_DW = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SLOT = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_LAT       = 3'd3,
      ST_DONE      = 3'd4
   } vram_rd_state_t;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int ctr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chr_gen_tmo_ctr.sv
// Clear/enable up-counter whose terminal-count flag is high while the count equals C_N-1.
module chr_gen_tmo_ctr
   import chr_gen_pkg::*;
#(
   parameter int C_N = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = ctr_width(C_N);
   localparam logic [W-1:0] TC_VAL = W'(C_N - 1);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en) begin
         cnt_reg <= cnt_reg + W'(1);
      end
   end

   assign tc = (cnt_reg == TC_VAL);

endmodule

// File: rtl/vram_rd_bridge.sv
// CPU readback engine: accepts a toggle-handshake read request, steals one free VRAM
// read-port slot (or times out), and returns the byte with an ack toggle and error flag.
module vram_rd_bridge
   import chr_gen_pkg::*;
#(
   parameter int C_AW     = C_VRAM_AW,
   parameter int C_DW     = C_VRAM_DW,
   parameter int C_RD_LAT = 2,
   parameter int C_TMO    = 4096
) (
   input  logic            NFSC_CK_i,
   input  logic            XSYS_R_i,
   input  logic            CPU_RD_REQ_TGL_i,
   input  logic [C_AW-1:0] CPU_RD_As_i,
   output logic [C_DW-1:0] CPU_RD_Ds_o,
   output logic            CPU_RD_ACK_TGL_o,
   output logic            CPU_RD_ERR_o,
   output logic            BUSY_o,
   input  logic            VRAM_FETCH_i,
   output logic [C_AW-1:0] VRAM_RAs_o,
   output logic            VRAM_RE_o,
   input  logic [C_DW-1:0] VRAM_RDs_i
);

   vram_rd_state_t  state_reg, state_next;
   logic [C_AW-1:0] addr_reg, addr_next;
   logic [C_AW-1:0] ras_reg, ras_next;
   logic [C_DW-1:0] ds_reg, ds_next;
   logic            ack_reg, ack_next;
   logic            err_reg, err_next;
   logic            busy_reg, busy_next;
   logic            re_reg, re_next;

   logic tmo_clr, tmo_en, tmo_tc;
   logic lat_clr, lat_en, lat_tc;

   chr_gen_tmo_ctr #(.C_N(C_TMO)) u_tmo_ctr (
      .clk   (NFSC_CK_i),
      .rst_n (XSYS_R_i),
      .clr   (tmo_clr),
      .en    (tmo_en),
      .tc    (tmo_tc)
   );

   chr_gen_tmo_ctr #(.C_N(C_RD_LAT)) u_lat_ctr (
      .clk   (NFSC_CK_i),
      .rst_n (XSYS_R_i),
      .clr   (lat_clr),
      .en    (lat_en),
      .tc    (lat_tc)
   );

   always_ff @(posedge NFSC_CK_i) begin
      if (!XSYS_R_i) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         ras_reg   <= '0;
         ds_reg    <= '0;
         ack_reg   <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         re_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         ras_reg   <= ras_next;
         ds_reg    <= ds_next;
         ack_reg   <= ack_next;
         err_reg   <= err_next;
         busy_reg  <= busy_next;
         re_reg    <= re_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      ras_next   = ras_reg;
      ds_next    = ds_reg;
      ack_next   = ack_reg;
      err_next   = err_reg;
      busy_next  = busy_reg;
      re_next    = 1'b0;
      tmo_clr    = 1'b0;
      tmo_en     = 1'b0;
      lat_clr    = 1'b0;
      lat_en     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (CPU_RD_REQ_TGL_i != ack_reg) begin
               addr_next  = CPU_RD_As_i;
               busy_next  = 1'b1;
               tmo_clr    = 1'b1;
               state_next = ST_WAIT_SLOT;
            end
         end
         ST_WAIT_SLOT: begin
            // A free slot takes priority over a timeout landing in the same cycle.
            if (!VRAM_FETCH_i) begin
               ras_next   = addr_reg;
               re_next    = 1'b1;
               state_next = ST_ISSUE;
            end else if (tmo_tc) begin
               ds_next    = '1;
               err_next   = 1'b1;
               busy_next  = 1'b0;
               state_next = ST_DONE;
            end else begin
               tmo_en = 1'b1;
            end
         end
         ST_ISSUE: begin
            lat_clr    = 1'b1;
            state_next = ST_LAT;
         end
         ST_LAT: begin
            if (lat_tc) begin
               ds_next    = VRAM_RDs_i;
               err_next   = 1'b0;
               busy_next  = 1'b0;
               state_next = ST_DONE;
            end else begin
               lat_en = 1'b1;
            end
         end
         ST_DONE: begin
            // Copying REQ (not inverting ACK) swallows any toggle made while busy.
            ack_next   = CPU_RD_REQ_TGL_i;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign CPU_RD_Ds_o      = ds_reg;
   assign CPU_RD_ACK_TGL_o = ack_reg;
   assign CPU_RD_ERR_o     = err_reg;
   assign BUSY_o           = busy_reg;
   assign VRAM_RAs_o       = ras_reg;
   assign VRAM_RE_o        = re_reg;

endmodule

// File: tb/tb_vram_rd_bridge.sv
// Self-checking bench: two bridges (LAT=2/TMO=16 and LAT=1/TMO=4096) against a timing/data reference.
module tb_vram_rd_bridge;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int LAT_A = 2;
   localparam int TMO_A = 16;
   localparam int LAT_B = 1;
   localparam int TMO_B = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic                fetch;
   logic [1:0]          req;
   logic [1:0][AW-1:0]  as_v;
   logic [1:0][DW-1:0]  ds;
   logic [1:0][DW-1:0]  rds;
   logic [1:0][AW-1:0]  ras;
   logic [1:0]          ack, err, busy, re;

   logic [DW-1:0] mem [1<<AW];
   logic [DW-1:0] pipe_a [LAT_A];
   logic [DW-1:0] pipe_b [LAT_B];

   int n_tests = 0;
   int n_fail  = 0;

   vram_rd_bridge #(.C_AW(AW), .C_DW(DW), .C_RD_LAT(LAT_A), .C_TMO(TMO_A)) dut_a (
      .NFSC_CK_i        (clk),
      .XSYS_R_i         (rst_n),
      .CPU_RD_REQ_TGL_i (req[0]),
      .CPU_RD_As_i      (as_v[0]),
      .CPU_RD_Ds_o      (ds[0]),
      .CPU_RD_ACK_TGL_o (ack[0]),
      .CPU_RD_ERR_o     (err[0]),
      .BUSY_o           (busy[0]),
      .VRAM_FETCH_i     (fetch),
      .VRAM_RAs_o       (ras[0]),
      .VRAM_RE_o        (re[0]),
      .VRAM_RDs_i       (rds[0])
   );

   vram_rd_bridge #(.C_AW(AW), .C_DW(DW), .C_RD_LAT(LAT_B), .C_TMO(TMO_B)) dut_b (
      .NFSC_CK_i        (clk),
      .XSYS_R_i         (rst_n),
      .CPU_RD_REQ_TGL_i (req[1]),
      .CPU_RD_As_i      (as_v[1]),
      .CPU_RD_Ds_o      (ds[1]),
      .CPU_RD_ACK_TGL_o (ack[1]),
      .CPU_RD_ERR_o     (err[1]),
      .BUSY_o           (busy[1]),
      .VRAM_FETCH_i     (fetch),
      .VRAM_RAs_o       (ras[1]),
      .VRAM_RE_o        (re[1]),
      .VRAM_RDs_i       (rds[1])
   );

   // VRAM read ports: data appears LAT edges after the RE-sampling edge, garbage otherwise.
   always @(posedge clk) begin
      pipe_a[0] <= re[0] ? mem[ras[0]] : DW'($urandom);
      for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
      pipe_b[0] <= re[1] ? mem[ras[1]] : DW'($urandom);
      for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign rds[0] = pipe_a[LAT_A-1];
   assign rds[1] = pipe_b[LAT_B-1];

   // One request on bridge sel with FETCH held high for n_fetch wait cycles.
   task automatic run_req(input int sel, input logic [AW-1:0] addr, input int n_fetch,
                          input string name);
      int lat, tmo, exp_lat, re_cnt, re_k, busy_cnt, ack_k;
      logic [AW-1:0] ras_seen;
      logic [DW-1:0] exp_ds;
      logic          exp_err, exp_ack;
      lat = (sel != 0) ? LAT_B : LAT_A;
      tmo = (sel != 0) ? TMO_B : TMO_A;
      if (n_fetch >= tmo) begin
         exp_lat = tmo + 1;
         exp_err = 1'b1;
         exp_ds  = '1;
      end else begin
         exp_lat = n_fetch + lat + 3;
         exp_err = 1'b0;
         exp_ds  = mem[addr];
      end
      @(negedge clk);
      as_v[sel] = addr;
      req[sel]  = ~req[sel];
      exp_ack   = req[sel];
      fetch     = (n_fetch > 0);
      re_cnt = 0; re_k = -1; busy_cnt = 0; ack_k = -1; ras_seen = '0;
      for (int k = 0; k < exp_lat + 20 && ack_k < 0; k++) begin
         @(posedge clk); #1;
         if (re[sel]) begin
            re_cnt++;
            if (re_k < 0) begin re_k = k; ras_seen = ras[sel]; end
         end
         if (busy[sel]) busy_cnt++;
         if (ack[sel] == exp_ack) ack_k = k;
         if (k == n_fetch) fetch = 1'b0;
      end
      fetch = 1'b0;
      $display("[TB] %s sel=%0d addr=%h wait=%0d ack_at=%0d ds=%h err=%b re=%0d",
               name, sel, addr, n_fetch, ack_k, ds[sel], err[sel], re_cnt);
      n_tests++;
      if (ack_k !== exp_lat) begin
         n_fail++; $display("FAIL %s ack_latency got=%0d exp=%0d", name, ack_k, exp_lat);
      end
      n_tests++;
      if (re_cnt !== (exp_err ? 0 : 1)) begin
         n_fail++; $display("FAIL %s re_count got=%0d exp=%0d", name, re_cnt, exp_err ? 0 : 1);
      end
      if (!exp_err) begin
         n_tests++;
         if (re_k !== n_fetch + 1 || ras_seen !== addr) begin
            n_fail++;
            $display("FAIL %s re_slot got k=%0d ras=%h exp k=%0d ras=%h",
                     name, re_k, ras_seen, n_fetch + 1, addr);
         end
      end
      n_tests++;
      if (ds[sel] !== exp_ds || err[sel] !== exp_err) begin
         n_fail++;
         $display("FAIL %s data got ds=%h err=%b exp ds=%h err=%b",
                  name, ds[sel], err[sel], exp_ds, exp_err);
      end
      n_tests++;
      if (busy_cnt !== exp_lat - 1) begin
         n_fail++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cnt, exp_lat - 1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fetch = 1'b0; req = '0; as_v = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_tests++;
         if ({ack[s], err[s], busy[s], re[s]} !== 4'b0 || ds[s] !== '0 || ras[s] !== '0) begin
            n_fail++;
            $display("FAIL reset sel=%0d got ack=%b err=%b busy=%b re=%b ds=%h ras=%h exp all 0",
                     s, ack[s], err[s], busy[s], re[s], ds[s], ras[s]);
         end
      end
      $display("[TB] reset checked");
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      mem[10'h123] = 8'h5A;
      run_req(0, 10'h123, 0, "basic");
   endtask

   task automatic test_fetch_hold();
      run_req(1, AW'($urandom), 100, "fetch_hold_100");
      run_req(0, AW'($urandom), 5, "fetch_hold_5");
      run_req(0, AW'($urandom), TMO_A - 1, "grant_at_terminal");
   endtask

   task automatic test_timeout();
      run_req(0, AW'($urandom), TMO_A, "timeout_exact");
      run_req(0, AW'($urandom), 40, "timeout_stuck");
      run_req(0, AW'($urandom), 0, "after_timeout");
   endtask

   task automatic test_reset_mid();
      int bad;
      @(negedge clk);
      req[0] = ~req[0];
      fetch  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (busy[0] !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid busy_before got=%b exp=1", busy[0]);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (ack[0] !== 1'b0 || ds[0] !== '0 || busy[0] !== 1'b0 || re[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid got ack=%b ds=%h busy=%b re=%b exp 0 0 0 0",
                  ack[0], ds[0], busy[0], re[0]);
      end
      req   = '0;
      rst_n = 1'b1;
      bad   = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (re[0] || ack[0]) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL reset_mid late_activity got=%0d exp=0", bad);
      end
      $display("[TB] reset_mid checked");
   endtask

   task automatic test_lost_toggle();
      logic [AW-1:0] a1, a2, ras_seen;
      int re_cnt;
      a1 = AW'($urandom);
      a2 = a1 ^ AW'(10'h155);
      mem[a1] = 8'hC3; mem[a2] = 8'h3C;
      @(negedge clk);
      as_v[0] = a1; req[0] = ~req[0]; fetch = 1'b0;
      re_cnt = 0; ras_seen = '0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin as_v[0] = a2; req[0] = ~req[0]; end
         if (re[0]) begin re_cnt++; ras_seen = ras[0]; end
      end
      $display("[TB] lost_toggle a1=%h a2=%h ds=%h ack=%b req=%b re=%0d",
               a1, a2, ds[0], ack[0], req[0], re_cnt);
      n_tests++;
      if (re_cnt !== 1 || ras_seen !== a1) begin
         n_fail++; $display("FAIL lost_toggle re got=%0d ras=%h exp=1 ras=%h", re_cnt, ras_seen, a1);
      end
      n_tests++;
      if (ds[0] !== mem[a1] || err[0] !== 1'b0) begin
         n_fail++; $display("FAIL lost_toggle data got=%h err=%b exp=%h err=0", ds[0], err[0], mem[a1]);
      end
      n_tests++;
      if (ack[0] !== req[0] || busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL lost_toggle hs got ack=%b busy=%b exp ack=%b busy=0",
                            ack[0], busy[0], req[0]);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) run_req(0, AW'($urandom), 0, "b2b_a");
      for (int i = 0; i < 3; i++) run_req(1, AW'($urandom), 0, "b2b_b");
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++)
         run_req(int'($urandom_range(1, 0)), AW'($urandom), int'($urandom_range(20, 0)), "random");
   endtask

   task automatic test_addr_max();
      mem[10'h3FF] = 8'hA7;
      run_req(1, 10'h3FF, 0, "addr_max");
      run_req(0, 10'h3FF, 0, "addr_max_a");
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom_range(255, 1));
      test_reset();
      test_basic();
      test_fetch_hold();
      test_timeout();
      test_reset_mid();
      test_lost_toggle();
      test_back_to_back();
      test_random();
      test_addr_max();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
